// File: rtl/dcd_frame_sequencer_pkg.sv
// Shared definitions for the DCD frame/row sequencer: state encoding,
// deserializer sample ordering and default widths.
package dcd_frame_sequencer_pkg;

    // Default widths of the row counter, frame counter and lane mask.
    localparam int ROW_W_DEF   = 10;
    localparam int FRAME_W_DEF = 16;
    localparam int N_CH_DEF    = 64;

    // Samples per deserialized word (one word per CLK_80 cycle).
    localparam int DES_W = 4;

    // Bit 0 of every deserialized word holds the earliest sample.
    localparam bit SAMPLE_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2
    } seq_state_t;

endpackage

// File: rtl/des4_edge_detect.sv
// Rising-edge finder for one 4-sample deserialized word. It keeps the last
// sample of the previous word so edges across word boundaries are seen.
module des4_edge_detect
    import dcd_frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DES_W-1:0] word,
    output logic             edge_found,
    output logic [1:0]       phase,
    output logic             multi
);

    logic             prev_q;
    logic [DES_W-1:0] ordered;
    logic [DES_W-1:0] rise;

    // Put the samples in time order, earliest at index 0.
    always_comb begin
        ordered = word;
        if (!SAMPLE_LSB_FIRST) begin
            for (int i = 0; i < DES_W; i++) begin
                ordered[i] = word[DES_W-1-i];
            end
        end
    end

    // Mark every 0->1 transition; report the earliest one and flag extras.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rise       = ordered & ~{ordered[DES_W-2:0], prev_q};
        edge_found = |rise;
        multi      = (rise & (rise - 4'd1)) != '0;
        phase      = '0;
        for (int i = DES_W - 1; i >= 0; i--) begin
            if (rise[i]) begin
                phase = i[1:0];
            end
        end
    end

    // Remember the latest sample every cycle, whatever the sequencer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            prev_q <= ordered[DES_W-1];
        end
    end

endmodule

// File: rtl/dcd_frame_sequencer.sv
// Frame/row sequencer for the DCD emulator readout path. Tracks frame and
// row position from deserialized FSYNC/R2S words and gates the output lanes.
module dcd_frame_sequencer
    import dcd_frame_sequencer_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int N_CH    = N_CH_DEF
) (
    input  logic               CLK_80,
    input  logic               RST_N,
    input  logic               ENABLE,
    input  logic [ROW_W-1:0]   CFG_ROWS,
    input  logic [N_CH-1:0]    CFG_CH_EN,
    input  logic               ERR_CLR,
    input  logic [DES_W-1:0]   FSYNC_DES,
    input  logic [DES_W-1:0]   R2S_DES,
    output logic               ROW_STROBE,
    output logic [1:0]         ROW_PHASE,
    output logic [ROW_W-1:0]   ROW_CNT,
    output logic [FRAME_W-1:0] FRAME_CNT,
    output logic               RUNNING,
    output logic [N_CH-1:0]    DISABLE_DO,
    output logic               ERR_SHORT,
    output logic               ERR_NOSYNC,
    output logic               ERR_GLITCH
);

    seq_state_t         state_q, state_d;
    logic               fs_found, r2_found, fs_multi, r2_multi;
    logic [1:0]         fs_phase, r2_phase;
    logic [ROW_W-1:0]   last_row;
    logic [ROW_W-1:0]   row_d;
    logic [FRAME_W-1:0] frame_d;
    logic               strobe_d;
    logic [1:0]         phase_d;
    logic               short_set, nosync_set, glitch_set;

    des4_edge_detect u_fs_edge (
        .clk        (CLK_80),
        .rst_n      (RST_N),
        .word       (FSYNC_DES),
        .edge_found (fs_found),
        .phase      (fs_phase),
        .multi      (fs_multi)
    );

    des4_edge_detect u_r2s_edge (
        .clk        (CLK_80),
        .rst_n      (RST_N),
        .word       (R2S_DES),
        .edge_found (r2_found),
        .phase      (r2_phase),
        .multi      (r2_multi)
    );

    assign last_row = CFG_ROWS - ROW_W'(1);

    // State register.
    always_ff @(posedge CLK_80 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping ENABLE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (ENABLE)   state_d = ST_WAIT_SYNC;
            ST_WAIT_SYNC: if (fs_found) state_d = ST_RUN;
            ST_RUN:       state_d = ST_RUN;
            default:      state_d = ST_IDLE;
        endcase
        if (!ENABLE) begin
            state_d = ST_IDLE;
        end
    end

    // Next values of the counters, strobe and error events.
    always_comb begin
        row_d      = ROW_CNT;
        frame_d    = FRAME_CNT;
        strobe_d   = 1'b0;
        phase_d    = ROW_PHASE;
        short_set  = 1'b0;
        nosync_set = 1'b0;
        glitch_set = (state_q != ST_IDLE) && (fs_multi || r2_multi);
        if (!ENABLE) begin
            row_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    row_d   = '0;
                    frame_d = '0;
                end
                ST_WAIT_SYNC: begin
                    // The very first FSYNC cannot be short: no frame was running.
                    if (fs_found) begin
                        row_d    = '0;
                        frame_d  = FRAME_CNT + FRAME_W'(1);
                        strobe_d = 1'b1;
                        phase_d  = fs_phase;
                    end
                end
                ST_RUN: begin
                    if (fs_found) begin
                        short_set = (ROW_CNT != last_row);
                        row_d     = '0;
                        frame_d   = FRAME_CNT + FRAME_W'(1);
                        strobe_d  = 1'b1;
                        phase_d   = fs_phase;
                    end else if (r2_found) begin
                        if (ROW_CNT == last_row) begin
                            row_d      = '0;
                            nosync_set = 1'b1;
                        end else begin
                            row_d = ROW_CNT + ROW_W'(1);
                        end
                        strobe_d = 1'b1;
                        phase_d  = r2_phase;
                    end
                end
                default: row_d = '0;
            endcase
        end
    end

    // Output registers; RUNNING and the lane mask follow the next state so
    // they switch together with the state register.
    always_ff @(posedge CLK_80 or negedge RST_N) begin
        if (!RST_N) begin
            ROW_STROBE <= 1'b0;
            ROW_PHASE  <= '0;
            ROW_CNT    <= '0;
            FRAME_CNT  <= '0;
            RUNNING    <= 1'b0;
            DISABLE_DO <= '1;
            ERR_SHORT  <= 1'b0;
            ERR_NOSYNC <= 1'b0;
            ERR_GLITCH <= 1'b0;
        end else begin
            ROW_STROBE <= strobe_d;
            ROW_PHASE  <= phase_d;
            ROW_CNT    <= row_d;
            FRAME_CNT  <= frame_d;
            RUNNING    <= (state_d == ST_RUN);
            DISABLE_DO <= (state_d == ST_RUN) ? ~CFG_CH_EN : '1;
            // A new error in the clearing cycle survives the clear.
            ERR_SHORT  <= (ERR_SHORT  & ~ERR_CLR) | short_set;
            ERR_NOSYNC <= (ERR_NOSYNC & ~ERR_CLR) | nosync_set;
            ERR_GLITCH <= (ERR_GLITCH & ~ERR_CLR) | glitch_set;
        end
    end

endmodule

// File: tb/tb_dcd_frame_sequencer.sv
// Self-checking bench for dcd_frame_sequencer: a behavioural model pushes the
// expected outputs for every driven word; they are popped one cycle later.
module tb_dcd_frame_sequencer;

    localparam int ROW_W   = 10;
    localparam int FRAME_W = 16;
    localparam int N_CH    = 64;

    logic               CLK_80;
    logic               RST_N;
    logic               ENABLE;
    logic [ROW_W-1:0]   CFG_ROWS;
    logic [N_CH-1:0]    CFG_CH_EN;
    logic               ERR_CLR;
    logic [3:0]         FSYNC_DES;
    logic [3:0]         R2S_DES;
    logic               ROW_STROBE;
    logic [1:0]         ROW_PHASE;
    logic [ROW_W-1:0]   ROW_CNT;
    logic [FRAME_W-1:0] FRAME_CNT;
    logic               RUNNING;
    logic [N_CH-1:0]    DISABLE_DO;
    logic               ERR_SHORT;
    logic               ERR_NOSYNC;
    logic               ERR_GLITCH;

    dcd_frame_sequencer #(.ROW_W(ROW_W), .FRAME_W(FRAME_W), .N_CH(N_CH)) dut (
        .CLK_80     (CLK_80),
        .RST_N      (RST_N),
        .ENABLE     (ENABLE),
        .CFG_ROWS   (CFG_ROWS),
        .CFG_CH_EN  (CFG_CH_EN),
        .ERR_CLR    (ERR_CLR),
        .FSYNC_DES  (FSYNC_DES),
        .R2S_DES    (R2S_DES),
        .ROW_STROBE (ROW_STROBE),
        .ROW_PHASE  (ROW_PHASE),
        .ROW_CNT    (ROW_CNT),
        .FRAME_CNT  (FRAME_CNT),
        .RUNNING    (RUNNING),
        .DISABLE_DO (DISABLE_DO),
        .ERR_SHORT  (ERR_SHORT),
        .ERR_NOSYNC (ERR_NOSYNC),
        .ERR_GLITCH (ERR_GLITCH)
    );

    typedef struct {
        logic               strobe;
        logic [1:0]         phase;
        logic [ROW_W-1:0]   row;
        logic [FRAME_W-1:0] frame;
        logic               running;
        logic [N_CH-1:0]    dis;
        logic               e_short;
        logic               e_nosync;
        logic               e_glitch;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: 0 idle, 1 waiting for sync, 2 running.
    int                 m_st;
    bit                 m_pfs, m_pr2;
    exp_t               m;

    always #5 CLK_80 = ~CLK_80;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void find_edge(input logic [3:0] w, input bit p,
                                      output bit found, output logic [1:0] ph,
                                      output bit multi);
        int         n;
        logic [4:0] v;
        n     = 0;
        v     = {w, p};
        ph    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i+1] && !v[i]) begin
                if (n == 0) ph = i[1:0];
                n++;
            end
        end
        found = (n > 0);
        multi = (n > 1);
    endfunction

    task automatic model_reset();
        m_st       = 0;
        m_pfs      = 1'b0;
        m_pr2      = 1'b0;
        m.strobe   = 1'b0;
        m.phase    = 2'd0;
        m.row      = '0;
        m.frame    = '0;
        m.running  = 1'b0;
        m.dis      = '1;
        m.e_short  = 1'b0;
        m.e_nosync = 1'b0;
        m.e_glitch = 1'b0;
    endtask

    // Drive one word pair, predict the outputs, then compare after the edge.
    task automatic step(input logic [3:0] fs, input logic [3:0] r2, input logic clr);
        bit         ff, rf, fm, rm, sset, nset, gset;
        logic [1:0] fp, rp;
        int         nst;
        logic [ROW_W-1:0] last;
        exp_t       got_exp;

        @(negedge CLK_80);
        FSYNC_DES = fs;
        R2S_DES   = r2;
        ERR_CLR   = clr;

        find_edge(fs, m_pfs, ff, fp, fm);
        find_edge(r2, m_pr2, rf, rp, rm);
        m_pfs    = fs[3];
        m_pr2    = r2[3];
        last     = CFG_ROWS - 1;
        gset     = (m_st != 0) && (fm || rm);
        sset     = 1'b0;
        nset     = 1'b0;
        m.strobe = 1'b0;
        nst      = m_st;
        if (!ENABLE) begin
            nst   = 0;
            m.row = '0;
        end else if (m_st == 0) begin
            nst     = 1;
            m.row   = '0;
            m.frame = '0;
        end else if (ff) begin
            if (m_st == 2 && m.row != last) sset = 1'b1;
            nst      = 2;
            m.row    = '0;
            m.frame  = m.frame + 1;
            m.strobe = 1'b1;
            m.phase  = fp;
        end else if (rf && m_st == 2) begin
            if (m.row == last) begin
                m.row = '0;
                nset  = 1'b1;
            end else begin
                m.row = m.row + 1;
            end
            m.strobe = 1'b1;
            m.phase  = rp;
        end
        m.e_short  = (m.e_short  && !clr) || sset;
        m.e_nosync = (m.e_nosync && !clr) || nset;
        m.e_glitch = (m.e_glitch && !clr) || gset;
        m_st       = nst;
        m.running  = (nst == 2);
        m.dis      = (nst == 2) ? ~CFG_CH_EN : '1;
        sb_q.push_back(m);

        @(posedge CLK_80);
        #1;
        ERR_CLR = 1'b0;
        got_exp = sb_q.pop_front();
        check("row_strobe", ROW_STROBE, got_exp.strobe);
        check("row_phase",  ROW_PHASE,  got_exp.phase);
        check("row_cnt",    ROW_CNT,    got_exp.row);
        check("frame_cnt",  FRAME_CNT,  got_exp.frame);
        check("running",    RUNNING,    got_exp.running);
        check("disable_do", DISABLE_DO, got_exp.dis);
        check("err_short",  ERR_SHORT,  got_exp.e_short);
        check("err_nosync", ERR_NOSYNC, got_exp.e_nosync);
        check("err_glitch", ERR_GLITCH, got_exp.e_glitch);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobe"}, ROW_STROBE, 1'b0);
        check({tag, "_phase"},  ROW_PHASE,  2'd0);
        check({tag, "_row"},    ROW_CNT,    '0);
        check({tag, "_frame"},  FRAME_CNT,  '0);
        check({tag, "_run"},    RUNNING,    1'b0);
        check({tag, "_dis"},    DISABLE_DO, 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, "_eshort"}, ERR_SHORT,  1'b0);
        check({tag, "_enosync"},ERR_NOSYNC, 1'b0);
        check({tag, "_eglitch"},ERR_GLITCH, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CLK_80    = 1'b0;
        RST_N     = 1'b0;
        ENABLE    = 1'b0;
        ERR_CLR   = 1'b0;
        FSYNC_DES = 4'b0;
        R2S_DES   = 4'b0;
        CFG_ROWS  = 10'd4;
        CFG_CH_EN = 64'h0000_0000_0000_00FF;
        model_reset();

        #12;
        check_reset_outputs("rst");
        @(negedge CLK_80);
        RST_N = 1'b1;

        // Frame start with FSYNC edge at sample 2.
        ENABLE = 1'b1;
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b1100, 4'b0000, 1'b0);
        check("start_strobe", ROW_STROBE, 1'b1);
        check("start_phase",  ROW_PHASE,  2'd2);
        check("start_frame",  FRAME_CNT,  16'd1);
        check("start_dis",    DISABLE_DO, 64'hFFFF_FFFF_FFFF_FF00);
        step(4'b0000, 4'b0000, 1'b0);

        // Full frame: three rows then FSYNC.
        for (int k = 1; k <= 3; k++) begin
            step(4'b0000, 4'b0001, 1'b0);
            check("full_row", ROW_CNT, 10'(k));
            step(4'b0000, 4'b0000, 1'b0);
        end
        step(4'b0001, 4'b0000, 1'b0);
        check("full_row0",   ROW_CNT,   10'd0);
        check("full_frame",  FRAME_CNT, 16'd2);
        check("full_eshort", ERR_SHORT, 1'b0);

        // Short frame: FSYNC after a single row.
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("short_set", ERR_SHORT, 1'b1);
        step(4'b0000, 4'b0000, 1'b0);

        // Missing sync: four rows wrap the counter.
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0001, 1'b0);
            step(4'b0000, 4'b0000, 1'b0);
        end
        check("nosync_row", ROW_CNT,    10'd0);
        check("nosync_set", ERR_NOSYNC, 1'b1);

        // Clear, then clear colliding with a new short event.
        step(4'b0000, 4'b0000, 1'b1);
        check("clr_short",  ERR_SHORT,  1'b0);
        check("clr_nosync", ERR_NOSYNC, 1'b0);
        step(4'b0001, 4'b0000, 1'b1);
        check("setwins_short", ERR_SHORT, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Glitch word, edge at last sample, and a steady-high word.
        step(4'b0000, 4'b0101, 1'b0);
        check("glitch_phase", ROW_PHASE,  2'd0);
        check("glitch_flag",  ERR_GLITCH, 1'b1);
        step(4'b0000, 4'b1000, 1'b0);
        check("late_phase", ROW_PHASE, 2'd3);
        step(4'b0000, 4'b1111, 1'b0);
        check("steady_strobe", ROW_STROBE, 1'b0);

        // FSYNC and R2S edges in the same word: FSYNC wins.
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0010, 4'b0001, 1'b0);
        check("both_phase", ROW_PHASE, 2'd1);
        check("both_row",   ROW_CNT,   10'd0);
        step(4'b0000, 4'b0000, 1'b1);

        // Drop ENABLE mid-frame, then re-enable.
        step(4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        ENABLE = 1'b0;
        step(4'b0000, 4'b0000, 1'b0);
        check("drop_dis",   DISABLE_DO, 64'hFFFF_FFFF_FFFF_FFFF);
        check("drop_row",   ROW_CNT,    10'd0);
        check("drop_frame", FRAME_CNT,  16'd5);
        step(4'b0000, 4'b0000, 1'b0);
        ENABLE = 1'b1;
        step(4'b0000, 4'b0000, 1'b0);
        check("reen_frame", FRAME_CNT, 16'd0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("reen_frame1", FRAME_CNT, 16'd1);

        // One row per frame.
        CFG_ROWS = 10'd1;
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b0);
        check("rows1_short", ERR_SHORT, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        check("rows1_nosync", ERR_NOSYNC, 1'b1);

        // Asynchronous reset while running.
        CFG_ROWS = 10'd4;
        step(4'b0000, 4'b0000, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge CLK_80);
        @(negedge CLK_80);
        RST_N = 1'b1;
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        check("post_rst_phase", ROW_PHASE, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
